// File: rtl/input_packet_injector_pkg.sv
// Shared definitions for the host packet injector: packet field layout
// used by the core grid and the injector FSM state encoding.
package input_packet_injector_pkg;

  localparam int PACKET_WIDTH = 30;

  localparam int DX_MSB   = 29;
  localparam int DX_LSB   = 21;
  localparam int DY_MSB   = 20;
  localparam int DY_LSB   = 12;
  localparam int AXON_MSB = 11;
  localparam int AXON_LSB = 4;
  localparam int TICK_MSB = 3;
  localparam int TICK_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/input_packet_injector_fwft_fifo.sv
// First-word-fall-through FIFO. Besides the current head it exposes the head
// and count as they will be after this cycle's push/pop.
module fwft_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         head_next_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign push_s = push_i & (count_q != CW'(DEPTH));
  assign pop_s  = pop_i & (count_q != CW'(0));

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // An entry pushed into an empty (or just-emptied) FIFO becomes the head directly.
    if ((count_q == CW'(0)) || (pop_s && (count_q == CW'(1)))) begin
      head_next_o = wdata_i;
    end else begin
      head_next_o = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/input_packet_injector.sv
// Host-side packet source for core 0's west input: buffers host packets and
// end-of-tick markers, releasing each tick's packets once the grid tick passes the marker.
module input_packet_injector #(
  parameter int PACKET_WIDTH = input_packet_injector_pkg::PACKET_WIDTH,
  parameter int DEPTH        = 16,
  parameter int NUM_TICKS    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         host_valid,
  input  logic                         host_marker,
  input  logic [PACKET_WIDTH-1:0]      host_packet,
  output logic                         host_ready,
  input  logic                         ren_in,
  output logic [PACKET_WIDTH-1:0]      packet_out,
  output logic                         buffer_empty,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic [$clog2(NUM_TICKS)-1:0] current_tick,
  output logic                         underflow_error,
  output logic                         tick_overrun_error
);

  import input_packet_injector_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(NUM_TICKS);
  localparam int EW = PACKET_WIDTH + 1;

  logic [EW-1:0] wdata_s, head_s, head_next_s;
  logic [CW-1:0] count_s, count_next_s;
  logic          push_s, pop_s, release_s;

  state_e        state_q, state_d;
  logic          tick_pending_q, tick_pending_d;
  logic [TW-1:0] cur_tick_q, cur_tick_d;
  logic          underflow_q, underflow_d;
  logic          overrun_q, overrun_d;

  assign host_ready = (count_s != CW'(DEPTH));
  assign push_s     = host_valid & host_ready;
  assign wdata_s    = host_marker ? {1'b1, {PACKET_WIDTH{1'b0}}} : {1'b0, host_packet};
  assign release_s  = (state_q == HOLD) & (tick | tick_pending_q);
  assign pop_s      = ((state_q == STREAM) & ren_in) | release_s;

  fwft_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst),
    .push_i       (push_s),
    .wdata_i      (wdata_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .head_next_o  (head_next_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

  // State follows the post-update head so the registered state always matches the FIFO head.
  always_comb begin
    state_d      = state_q;
    buffer_empty = 1'b1;
    packet_out   = {PACKET_WIDTH{1'b0}};
    if (count_next_s == CW'(0)) begin
      state_d = EMPTY;
    end else if (head_next_s[EW-1]) begin
      state_d = HOLD;
    end else begin
      state_d = STREAM;
    end
    case (state_q)
      STREAM: begin
        buffer_empty = head_s[EW-1];
        packet_out   = head_s[EW-1] ? {PACKET_WIDTH{1'b0}} : head_s[PACKET_WIDTH-1:0];
      end
      EMPTY, HOLD: begin
        buffer_empty = 1'b1;
        packet_out   = {PACKET_WIDTH{1'b0}};
      end
      default: begin
        buffer_empty = 1'b1;
        packet_out   = {PACKET_WIDTH{1'b0}};
      end
    endcase
  end

  always_comb begin
    tick_pending_d = tick_pending_q;
    cur_tick_d     = cur_tick_q;
    if (release_s) begin
      tick_pending_d = 1'b0;
      cur_tick_d     = (cur_tick_q == TW'(NUM_TICKS - 1)) ? TW'(0) : cur_tick_q + TW'(1);
    end else if (tick) begin
      tick_pending_d = 1'b1;
    end else begin
      tick_pending_d = tick_pending_q;
    end
    underflow_d = underflow_q | (ren_in & (state_q != STREAM));
    overrun_d   = overrun_q | (tick & tick_pending_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= EMPTY;
      tick_pending_q <= 1'b0;
      cur_tick_q     <= TW'(0);
      underflow_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_pending_q <= tick_pending_d;
      cur_tick_q     <= cur_tick_d;
      underflow_q    <= underflow_d;
      overrun_q      <= overrun_d;
    end
  end

  assign fifo_count         = count_s;
  assign current_tick       = cur_tick_q;
  assign underflow_error    = underflow_q;
  assign tick_overrun_error = overrun_q;

endmodule

// File: tb/tb_input_packet_injector.sv
// Directed bench for input_packet_injector: packet flow, marker release,
// early tick, full/wrap behaviour, errors and asynchronous reset.
module tb_input_packet_injector;

  localparam int PW    = 30;
  localparam int DEPTH = 16;
  localparam int NT    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          host_valid;
  logic          host_marker;
  logic [PW-1:0] host_packet;
  logic          host_ready;
  logic          ren_in;
  logic [PW-1:0] packet_out;
  logic          buffer_empty;
  logic [4:0]    fifo_count;
  logic [3:0]    current_tick;
  logic          underflow_error;
  logic          tick_overrun_error;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  input_packet_injector #(
    .PACKET_WIDTH (PW),
    .DEPTH        (DEPTH),
    .NUM_TICKS    (NT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .tick               (tick),
    .host_valid         (host_valid),
    .host_marker        (host_marker),
    .host_packet        (host_packet),
    .host_ready         (host_ready),
    .ren_in             (ren_in),
    .packet_out         (packet_out),
    .buffer_empty       (buffer_empty),
    .fifo_count         (fifo_count),
    .current_tick       (current_tick),
    .underflow_error    (underflow_error),
    .tick_overrun_error (tick_overrun_error)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mk, input logic [PW-1:0] p);
    host_valid  = 1'b1;
    host_marker = mk;
    host_packet = p;
    cyc();
    host_valid  = 1'b0;
    host_marker = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; host_valid = 1'b0; host_marker = 1'b0;
    host_packet = 30'h0; ren_in = 1'b0;
    cyc(); cyc();
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", buffer_empty); end
    n_vec++; if (packet_out !== 30'h0) begin n_err++; $display("FAIL reset_packet: got %h want 0", packet_out); end
    n_vec++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", host_ready); end
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_vec++; if (current_tick !== 4'd0) begin n_err++; $display("FAIL reset_tick: got %0d want 0", current_tick); end
    n_vec++; if ({underflow_error, tick_overrun_error} !== 2'b00) begin n_err++; $display("FAIL reset_errors: got %b want 00", {underflow_error, tick_overrun_error}); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    push(1'b0, 30'h0000_1234);
    n_vec++; if (buffer_empty !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", buffer_empty); end
    n_vec++; if (packet_out !== 30'h0000_1234) begin n_err++; $display("FAIL single_packet: got %h want 00001234", packet_out); end
    n_vec++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    ren_in = 1'b1; cyc(); ren_in = 1'b0;
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty: got %b want 1", buffer_empty); end
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", fifo_count); end
    n_vec++; if (packet_out !== 30'h0) begin n_err++; $display("FAIL single_pop_packet: got %h want 0", packet_out); end
  endtask

  task automatic test_marker_release();
    push(1'b0, 30'h0000_1111);
    push(1'b0, 30'h0000_2222);
    push(1'b1, 30'h3FFF_FFFF);
    push(1'b0, 30'h0000_3333);
    n_vec++; if (fifo_count !== 5'd4) begin n_err++; $display("FAIL mk_count4: got %0d want 4", fifo_count); end
    n_vec++; if (packet_out !== 30'h0000_1111) begin n_err++; $display("FAIL mk_p1: got %h want 00001111", packet_out); end
    ren_in = 1'b1; cyc();
    n_vec++; if (packet_out !== 30'h0000_2222) begin n_err++; $display("FAIL mk_p2: got %h want 00002222", packet_out); end
    cyc(); ren_in = 1'b0;
    cyc();
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL mk_hold_empty: got %b want 1", buffer_empty); end
    n_vec++; if (fifo_count !== 5'd2) begin n_err++; $display("FAIL mk_hold_count: got %0d want 2", fifo_count); end
    n_vec++; if (current_tick !== 4'd0) begin n_err++; $display("FAIL mk_hold_tick: got %0d want 0", current_tick); end
    tick = 1'b1; cyc(); tick = 1'b0;
    n_vec++; if (current_tick !== 4'd1) begin n_err++; $display("FAIL mk_release_tick: got %0d want 1", current_tick); end
    n_vec++; if (buffer_empty !== 1'b0) begin n_err++; $display("FAIL mk_release_empty: got %b want 0", buffer_empty); end
    n_vec++; if (packet_out !== 30'h0000_3333) begin n_err++; $display("FAIL mk_p3: got %h want 00003333", packet_out); end
    n_vec++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL mk_release_count: got %0d want 1", fifo_count); end
    ren_in = 1'b1; cyc(); ren_in = 1'b0;
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL mk_drained: got %b want 1", buffer_empty); end
  endtask

  task automatic test_early_tick();
    push(1'b0, 30'h0000_4444);
    push(1'b1, 30'h0);
    push(1'b0, 30'h0000_5555);
    tick = 1'b1; cyc(); tick = 1'b0;
    n_vec++; if (current_tick !== 4'd1) begin n_err++; $display("FAIL early_tick_hold: got %0d want 1", current_tick); end
    n_vec++; if (packet_out !== 30'h0000_4444) begin n_err++; $display("FAIL early_p4: got %h want 00004444", packet_out); end
    ren_in = 1'b1; cyc(); ren_in = 1'b0;
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL early_at_marker: got %b want 1", buffer_empty); end
    cyc();
    n_vec++; if (current_tick !== 4'd2) begin n_err++; $display("FAIL early_release_tick: got %0d want 2", current_tick); end
    n_vec++; if (packet_out !== 30'h0000_5555) begin n_err++; $display("FAIL early_p5: got %h want 00005555", packet_out); end
    n_vec++; if (tick_overrun_error !== 1'b0) begin n_err++; $display("FAIL early_no_overrun: got %b want 0", tick_overrun_error); end
    ren_in = 1'b1; cyc(); ren_in = 1'b0;
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL early_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_full_wrap();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b want 1", i, host_ready); end
      push(1'b0, 30'h100 + 30'(i));
      exp_q.push_back(30'h100 + 30'(i));
    end
    n_vec++; if (host_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", host_ready); end
    n_vec++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", fifo_count); end
    host_valid = 1'b1; host_packet = 30'h3AB_CDEF; ren_in = 1'b1;
    n_vec++; if (packet_out !== exp_q[0]) begin n_err++; $display("FAIL full_head: got %h want %h", packet_out, exp_q[0]); end
    cyc();
    host_valid = 1'b0; ren_in = 1'b0;
    void'(exp_q.pop_front());
    n_vec++; if (fifo_count !== 5'd15) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 15", fifo_count); end
    n_vec++; if (host_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_rise: got %b want 1", host_ready); end
    for (int i = 0; i < 16; i++) begin
      host_valid = 1'b1; host_packet = 30'h200 + 30'(i); ren_in = 1'b1;
      n_vec++; if (packet_out !== exp_q[0]) begin n_err++; $display("FAIL stream_head_%0d: got %h want %h", i, packet_out, exp_q[0]); end
      cyc();
      void'(exp_q.pop_front());
      exp_q.push_back(30'h200 + 30'(i));
      n_vec++; if (fifo_count !== 5'd15) begin n_err++; $display("FAIL stream_count_%0d: got %0d want 15", i, fifo_count); end
    end
    host_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      ren_in = 1'b1;
      n_vec++; if (packet_out !== exp_q[0]) begin n_err++; $display("FAIL drain_head_%0d: got %h want %h", i, packet_out, exp_q[0]); end
      cyc();
      void'(exp_q.pop_front());
    end
    ren_in = 1'b0;
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", buffer_empty); end
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", fifo_count); end
    n_vec++; if (underflow_error !== 1'b0) begin n_err++; $display("FAIL wrap_no_underflow: got %b want 0", underflow_error); end
  endtask

  task automatic test_errors();
    ren_in = 1'b1; cyc(); ren_in = 1'b0;
    n_vec++; if (underflow_error !== 1'b1) begin n_err++; $display("FAIL underflow_set: got %b want 1", underflow_error); end
    cyc();
    n_vec++; if (underflow_error !== 1'b1) begin n_err++; $display("FAIL underflow_sticky: got %b want 1", underflow_error); end
    tick = 1'b1; cyc(); tick = 1'b0;
    n_vec++; if (tick_overrun_error !== 1'b0) begin n_err++; $display("FAIL overrun_first: got %b want 0", tick_overrun_error); end
    tick = 1'b1; cyc(); tick = 1'b0;
    n_vec++; if (tick_overrun_error !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", tick_overrun_error); end
    cyc();
    n_vec++; if (tick_overrun_error !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", tick_overrun_error); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 30'h500 + 30'(i));
    end
    n_vec++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL mid_count5: got %0d want 5", fifo_count); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (buffer_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", buffer_empty); end
    n_vec++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    n_vec++; if (current_tick !== 4'd0) begin n_err++; $display("FAIL mid_tick: got %0d want 0", current_tick); end
    n_vec++; if ({underflow_error, tick_overrun_error} !== 2'b00) begin n_err++; $display("FAIL mid_errors: got %b want 00", {underflow_error, tick_overrun_error}); end
    n_vec++; if (packet_out !== 30'h0) begin n_err++; $display("FAIL mid_packet: got %h want 0", packet_out); end
    cyc();
    rst = 1'b1;
    cyc();
    push(1'b0, 30'h0000_0777);
    n_vec++; if (packet_out !== 30'h0000_0777) begin n_err++; $display("FAIL post_reset_packet: got %h want 00000777", packet_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_marker_release();
    test_early_tick();
    test_full_wrap();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_packet_injector.md
# input_packet_injector

Host-side packet source feeding the core grid's west input of core 0. It accepts spike packets and end-of-tick markers from the host over a valid/ready handshake. It stores them in a first-word-fall-through FIFO and presents packets to the grid through the empty/read-enable input-buffer protocol. It releases each tick's packets only after the grid's `tick` has advanced past the preceding marker.

## Interface
- PACKET_WIDTH, 30, packet width: dx(9) + dy(9) + axon(8) + tick(4).
- DEPTH, 16, FIFO entries; power of two, ≥2.
- NUM_TICKS, 16, modulus of `current_tick`.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- tick  in  1  one-cycle tick pulse, same as the grid's `tick`.
- host_valid  in  1  host offers an entry.
- host_marker  in  1  with host_valid: the entry is an end-of-tick marker; host_packet is ignored.
- host_packet  in  PACKET_WIDTH  packet payload.
- host_ready  out  1  entry accepted when host_valid & host_ready.
- ren_in  in  1  grid read enable (grid `ren_to_input_buffer`).
- packet_out  out  PACKET_WIDTH  head packet (to grid `packet_in`).
- buffer_empty  out  1  to grid `input_buffer_empty`.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries, markers included.
- current_tick  out  $clog2(NUM_TICKS)  count of markers consumed, wrapping.
- underflow_error  out  1  sticky: ren_in while buffer_empty.
- tick_overrun_error  out  1  sticky: tick while a tick is already pending.

## Operation
- Each entry is {is_marker, packet}, PACKET_WIDTH+1 bits.
- Write pointer, read pointer and count update on accepted pushes and on pops.
- host_ready = (fifo_count != DEPTH). It is combinational from count only and does not depend on pops in the same cycle.
- FSM:
  - EMPTY: count == 0.
  - STREAM: head is a packet.
  - HOLD: head is a marker.
  - The state is registered and recomputed every cycle from the post-update head and count.
- buffer_empty = 1 in EMPTY and HOLD, and 0 in STREAM.
- packet_out = head payload in STREAM, and 0 otherwise.
- Pops:
  - In STREAM, ren_in pops the head packet.
  - In EMPTY or HOLD, ren_in is ignored and sets underflow_error.
- Tick handling:
  - tick_pending is set by tick while not in HOLD.
  - A tick that arrives while tick_pending = 1 sets tick_overrun_error; tick_pending stays 1.
  - In HOLD, when tick | tick_pending is true, the marker is popped, tick_pending is cleared and current_tick is incremented mod NUM_TICKS. This happens on the same edge.
- Simultaneous push and pop: both take effect, and count is unchanged.
- Push while full: not accepted, because host_ready = 0. Host data is held by the host.
- Reset (asserted asynchronously, also mid-operation):
  - Pointers, count, tick_pending, current_tick and both errors are cleared, and the state goes to EMPTY.
  - Resulting outputs: buffer_empty = 1, packet_out = 0, host_ready = 1, fifo_count = 0.
  - FIFO contents are don't-care.

## Timing
- A push accepted at edge n appears at the head and is visible on buffer_empty/packet_out after edge n, when it is the only entry. Latency is 1 cycle.
- A pop on edge n shows the next head after edge n. Back-to-back ren_in every cycle drains one packet per cycle.
- Marker release: with tick high in cycle n in HOLD, the marker pops at edge n. A following packet is presented (buffer_empty = 0) in cycle n+1.
- host_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- The error flags assert in the cycle after the offending event and hold until reset.

## Structure
- A shared package holds PACKET_WIDTH and the DX/DY/axon/tick field MSB/LSB constants used by the grid, and a state enum {EMPTY, STREAM, HOLD}.
- A single sub-module, `fwft_fifo` (DEPTH × (PACKET_WIDTH+1), push/pop/count/head), is natural. The injector top adds the FSM, tick logic and errors.

## Test plan
- After reset, push packet 0x0000_1234 → buffer_empty = 0 and packet_out = 0x0000_1234 next cycle; ren_in pop → buffer_empty = 1 and fifo_count = 0.
- Push P1, P2, marker, P3; drain with ren_in → P1 and P2 are delivered, then buffer_empty holds 1 with fifo_count = 2. A tick pulse → marker pops, current_tick = 1, P3 is presented the next cycle.
- Early tick: tick before the marker reaches the head → tick_pending is set; the marker pops on the edge it reaches the head with no further tick, and current_tick increments.
- Fill with 16 packets → host_ready = 0. Push and pop in the same cycle at full → no push is accepted. Pop alone → host_ready = 1 next cycle. Order is preserved across pointer wrap (32 packets total).
- Errors: ren_in while empty → underflow_error = 1 and sticky. Two ticks with no marker consumed → tick_overrun_error = 1.
- Reset asserted mid-stream with 5 entries held → immediately buffer_empty = 1, fifo_count = 0, current_tick = 0, errors = 0.
